// File: rtl/clock_div_prog.sv
// clock_div_prog: bank of independent programmable clock dividers.
// Each channel counts 0..A and then wraps, so its period is A+1 cycles.
// A new divisor is written into a shadow register and only takes effect
// at the next period start, which keeps every output period glitch-free.
// Outputs are registered and derived from the post-edge channel state.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | channel stopped: counter held at 0, clk_out/tick low
// ST_RUN   | channel counting 0..A; period start when the counter wraps
module clock_div_prog #(
  parameter int p_nchan     = 4,
  parameter int p_width     = 12,
  parameter int p_reset_div = 4095,
  localparam int p_cw       = (p_nchan > 1) ? $clog2(p_nchan) : 1
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic [p_nchan-1:0] en,
  input  logic               wr_en,
  input  logic [p_cw-1:0]    wr_chan,
  input  logic [p_width-1:0] wr_div,
  input  logic [p_nchan-1:0] mode,
  output logic [p_nchan-1:0] clk_out,
  output logic [p_nchan-1:0] tick,
  output logic [p_nchan-1:0] pend
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [p_width-1:0] RstDiv = p_width'(p_reset_div);

  for (genvar g = 0; g < p_nchan; g++) begin : g_chan
    logic [p_width-1:0] s_q, s_d;
    logic [p_width-1:0] a_q, a_d;
    logic [p_width-1:0] c_q, c_d;
    state_t             st_q, st_d;
    logic               pend_q, pend_d;
    logic               clk_q, clk_d;
    logic               tick_q, tick_d;
    logic               wr_hit;

    // Channel numbers that do not exist never match, so out-of-range
    // writes fall through without touching any channel.
    assign wr_hit = wr_en && (32'(wr_chan) == 32'(g));

    // Next-state and next-output computation for one channel.
    always_comb begin
      s_d    = s_q;
      a_d    = a_q;
      c_d    = c_q;
      st_d   = st_q;
      pend_d = pend_q;
      if (!en[g]) begin
        st_d = ST_IDLE;
        c_d  = '0;
      end else if (st_q == ST_IDLE || c_q == a_q) begin
        // Period start: adopt the shadow divisor as it stood before this edge.
        st_d   = ST_RUN;
        c_d    = '0;
        a_d    = s_q;
        pend_d = 1'b0;
      end else begin
        c_d = c_q + p_width'(1);
      end
      // A write on a period-start edge wins over the clear, so the new
      // value stays pending until the following period start.
      if (wr_hit) begin
        s_d    = wr_div;
        pend_d = 1'b1;
      end
      tick_d = (st_d == ST_RUN) && (c_d == '0);
      if (st_d != ST_RUN) begin
        clk_d = 1'b0;
      end else if (mode[g]) begin
        clk_d = (c_d == '0);
      end else begin
        clk_d = (c_d <= (a_d >> 1));
      end
    end

    // Channel registers with synchronous reset.
    always_ff @(posedge clk_in) begin
      if (rst) begin
        s_q    <= RstDiv;
        a_q    <= RstDiv;
        c_q    <= '0;
        st_q   <= ST_IDLE;
        pend_q <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        s_q    <= s_d;
        a_q    <= a_d;
        c_q    <= c_d;
        st_q   <= st_d;
        pend_q <= pend_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
      end
    end

    assign clk_out[g] = clk_q;
    assign tick[g]    = tick_q;
    assign pend[g]    = pend_q;
  end

endmodule

// File: tb/tb_clock_div_prog.sv
// Directed bench for clock_div_prog. Stimulus pushes expected per-cycle
// outputs into a queue; a monitor on the falling edge pops and compares.
module tb_clock_div_prog;

  logic       clk_in = 1'b0;
  logic       rst;

  logic [3:0]  en_a, mode_a, clk_out_a, tick_a, pend_a;
  logic        wr_en_a;
  logic [1:0]  wr_chan_a;
  logic [11:0] wr_div_a;

  logic [2:0]  en_b, mode_b, clk_out_b, tick_b, pend_b;
  logic        wr_en_b;
  logic [1:0]  wr_chan_b;
  logic [3:0]  wr_div_b;

  clock_div_prog dut_a (
    .clk_in(clk_in), .rst(rst), .en(en_a), .wr_en(wr_en_a), .wr_chan(wr_chan_a),
    .wr_div(wr_div_a), .mode(mode_a), .clk_out(clk_out_a), .tick(tick_a), .pend(pend_a)
  );

  clock_div_prog #(.p_nchan(3), .p_width(4), .p_reset_div(9)) dut_b (
    .clk_in(clk_in), .rst(rst), .en(en_b), .wr_en(wr_en_b), .wr_chan(wr_chan_b),
    .wr_div(wr_div_b), .mode(mode_b), .clk_out(clk_out_b), .tick(tick_b), .pend(pend_b)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int    dut;
    int    ch;
    logic  ck;
    logic  tk;
    logic  pd;
    string nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  exp_t m_e;
  logic [2:0] act;

  function automatic void push(int dut, int ch, logic ck, logic tk, logic pd, string nm);
    exp_t e;
    e.dut = dut; e.ch = ch; e.ck = ck; e.tk = tk; e.pd = pd; e.nm = nm;
    q.push_back(e);
  endfunction

  // Monitor: compare every queued expectation against the settled outputs.
  always @(negedge clk_in) begin
    while (q.size() > 0) begin
      m_e = q.pop_front();
      if (m_e.dut == 0)
        act = {clk_out_a[m_e.ch[1:0]], tick_a[m_e.ch[1:0]], pend_a[m_e.ch[1:0]]};
      else
        act = {clk_out_b[m_e.ch[1:0]], tick_b[m_e.ch[1:0]], pend_b[m_e.ch[1:0]]};
      checks++;
      if (act !== {m_e.ck, m_e.tk, m_e.pd}) begin
        errors++;
        $display("FAIL %s dut%0d ch%0d t=%0t: clk/tick/pend got %b want %b",
                 m_e.nm, m_e.dut, m_e.ch, $time, act, {m_e.ck, m_e.tk, m_e.pd});
      end
    end
  end

  task automatic edge1();
    @(posedge clk_in);
    #1;
  endtask

  // Expect a running channel: cycle k of the period is k%(hi+lo).
  task automatic expect_run(input int dut, input int mask, input int hi, input int lo,
                            input bit pulse, input int k0, input int n, input logic pd,
                            input string nm);
    int p;
    int ph;
    logic tk;
    logic ck;
    p = hi + lo;
    for (int k = k0; k < k0 + n; k++) begin
      edge1();
      ph = k % p;
      tk = (ph == 0);
      ck = pulse ? tk : (ph < hi);
      for (int c = 0; c < 4; c++)
        if (mask[c]) push(dut, c, ck, tk, pd, nm);
    end
  endtask

  task automatic expect_idle(input int dut, input int mask, input int n, input logic pd,
                             input string nm);
    for (int k = 0; k < n; k++) begin
      edge1();
      for (int c = 0; c < 4; c++)
        if (mask[c]) push(dut, c, 1'b0, 1'b0, pd, nm);
    end
  endtask

  task automatic wr_a(input int ch, input int d);
    wr_en_a = 1'b1; wr_chan_a = 2'(ch); wr_div_a = 12'(d);
    edge1();
    wr_en_a = 1'b0;
    push(0, ch, 1'b0, 1'b0, 1'b1, "wr_pend");
  endtask

  task automatic wr_b(input int ch, input int d);
    wr_en_b = 1'b1; wr_chan_b = 2'(ch); wr_div_b = 4'(d);
    edge1();
    wr_en_b = 1'b0;
    push(1, ch, 1'b0, 1'b0, 1'b1, "wr_pend_b");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en_a = '0; mode_a = '0; wr_en_a = 1'b0; wr_chan_a = '0; wr_div_a = '0;
    en_b = '0; mode_b = '0; wr_en_b = 1'b0; wr_chan_b = '0; wr_div_b = '0;
    edge1();
    edge1();
    for (int c = 0; c < 4; c++) push(0, c, 1'b0, 1'b0, 1'b0, "reset_a");
    for (int c = 0; c < 3; c++) push(1, c, 1'b0, 1'b0, 1'b0, "reset_b");
    rst = 1'b0;

    // Basic square wave, D=5: 1,1,1,0,0,0.
    wr_a(0, 5);
    en_a[0] = 1'b1;
    expect_run(0, 4'b0001, 3, 3, 1'b0, 0, 18, 1'b0, "sq_d5");
    en_a[0] = 1'b0;
    expect_idle(0, 4'b0001, 1, 1'b0, "sq_d5_off");

    // Pulse mode then square mode on ch1, D=4; then back to pulse mid-period.
    wr_a(1, 4);
    mode_a[1] = 1'b1;
    en_a[1] = 1'b1;
    expect_run(0, 4'b0010, 1, 4, 1'b1, 0, 10, 1'b0, "pulse_d4");
    mode_a[1] = 1'b0;
    expect_run(0, 4'b0010, 3, 2, 1'b0, 0, 12, 1'b0, "sq_d4");
    mode_a[1] = 1'b1;
    expect_run(0, 4'b0010, 1, 4, 1'b1, 2, 8, 1'b0, "mode_mid");
    en_a[1] = 1'b0;
    mode_a[1] = 1'b0;
    expect_idle(0, 4'b0010, 1, 1'b0, "d4_off");

    // Write landing on the period-start edge.
    wr_a(0, 3);
    en_a[0] = 1'b1;
    expect_run(0, 4'b0001, 2, 2, 1'b0, 0, 8, 1'b0, "bnd_d3");
    wr_en_a = 1'b1; wr_chan_a = 2'd0; wr_div_a = 12'd7;
    edge1();
    wr_en_a = 1'b0;
    push(0, 0, 1'b1, 1'b1, 1'b1, "bnd_start");
    expect_run(0, 4'b0001, 2, 2, 1'b0, 1, 3, 1'b1, "bnd_old_period");
    expect_run(0, 4'b0001, 4, 4, 1'b0, 0, 16, 1'b0, "bnd_new_period");
    en_a[0] = 1'b0;
    expect_idle(0, 4'b0001, 1, 1'b0, "bnd_off");

    // Disable mid-period on ch2, D=9.
    wr_a(2, 9);
    en_a[2] = 1'b1;
    expect_run(0, 4'b0100, 5, 5, 1'b0, 0, 5, 1'b0, "dis_pre");
    en_a[2] = 1'b0;
    expect_idle(0, 4'b0100, 3, 1'b0, "dis_hold");
    en_a[2] = 1'b1;
    expect_run(0, 4'b0100, 5, 5, 1'b0, 0, 10, 1'b0, "dis_restart");

    // D=0 in square mode: constant high with a tick every cycle.
    wr_a(3, 0);
    en_a[3] = 1'b1;
    expect_run(0, 4'b1000, 1, 0, 1'b0, 0, 6, 1'b0, "d0");

    // Narrow instance: D=15 at p_width=4, plus an out-of-range write.
    wr_b(0, 15);
    en_b[0] = 1'b1;
    expect_run(1, 4'b0001, 8, 8, 1'b0, 0, 20, 1'b0, "dmax");
    wr_en_b = 1'b1; wr_chan_b = 2'd3; wr_div_b = 4'd2;
    edge1();
    wr_en_b = 1'b0;
    push(1, 0, 1'b1, 1'b0, 1'b0, "bad_chan_ch0");
    push(1, 1, 1'b0, 1'b0, 1'b0, "bad_chan_ch1");
    push(1, 2, 1'b0, 1'b0, 1'b0, "bad_chan_ch2");
    expect_run(1, 4'b0001, 8, 8, 1'b0, 21, 27, 1'b0, "dmax_after_bad");
    en_b[0] = 1'b0;

    // Reset mid-operation with all channels running and a write during reset.
    en_a = 4'b1111;
    for (int k = 0; k < 5; k++) edge1();
    rst = 1'b1;
    wr_en_a = 1'b1; wr_chan_a = 2'd1; wr_div_a = 12'd2;
    edge1();
    for (int c = 0; c < 4; c++) push(0, c, 1'b0, 1'b0, 1'b0, "rst_mid");
    rst = 1'b0;
    wr_en_a = 1'b0;
    expect_run(0, 4'b1111, 2048, 2048, 1'b0, 0, 4097, 1'b0, "div4096");
    en_a = '0;

    @(negedge clk_in);
    @(negedge clk_in);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_div_prog.md
CLOCK_DIV_PROG -- requirements
Module: clock_div_prog

Interface
REQ-001 Parameters SHALL be:
- p_nchan, default 4, number of independent divider channels (>=1).
- p_width, default 12, divisor/counter width in bits (>=2).
- p_reset_div, default 4095, divisor loaded into every channel at reset.
REQ-002 Ports SHALL be:
- clk_in  in  1  clock.
- rst  in  1  reset.
- en  in  p_nchan  per-channel run enable.
- wr_en  in  1  divisor write strobe.
- wr_chan  in  max(1,$clog2(p_nchan))  target channel of write.
- wr_div  in  p_width  divisor value D; channel period = D+1 cycles.
- mode  in  p_nchan  per-channel output mode: 0 = square, 1 = pulse.
- clk_out  out  p_nchan  divided clock per channel.
- tick  out  p_nchan  one-cycle strobe at each period start.
- pend  out  p_nchan  written divisor not yet applied.
REQ-003 Reset SHALL be rst, synchronous, active-high; clock SHALL be clk_in.

Function
REQ-004 Each channel SHALL hold: shadow divisor S, active divisor A, counter C (p_width bits), run flag R and pend flag.
REQ-005 Channel state machine SHALL have two states:
- IDLE: R=0. C=0 and clk_out=tick=0.
- RUN: R=1. C counts 0..A, then wraps.
REQ-006 Transition IDLE->RUN SHALL occur on a clock edge with en[c]=1. At that edge: C<=0, A<=S, pend<=0, R<=1.
REQ-007 In RUN at an edge with en[c]=1:
- If C==A: C<=0, A<=S, pend<=0 (period start).
- Otherwise: C<=C+1.
REQ-008 Any edge with en[c]=0 SHALL force IDLE (C<=0, R<=0), including mid-period; S and pend SHALL be retained.
REQ-009 All outputs SHALL be registered and consistent with the post-edge C, A and R values; there SHALL be no combinational path from any input to any output.
REQ-010 tick[c] SHALL be 1 exactly in cycles where R=1 and C==0.
REQ-011 Square mode: clk_out[c]=1 iff R=1 and C <= (A>>1).
- High time = floor(A/2)+1 cycles; low time = ceil(A/2) cycles.
- For A=0, clk_out SHALL be constant 1 while R=1.
REQ-012 Pulse mode: clk_out[c] SHALL equal tick[c].
REQ-013 A mode[c] change SHALL affect clk_out from the next edge without disturbing C.
REQ-014 A write (wr_en=1, wr_chan<p_nchan) SHALL set S[wr_chan]<=wr_div and pend<=1. Writes with wr_chan>=p_nchan SHALL be ignored.
REQ-015 A write coinciding with a period-start edge on the same channel SHALL NOT be applied at that edge: A takes the pre-edge S, and pend SHALL remain 1 afterwards.
REQ-016 Repeated writes before a period start SHALL leave only the last value in S.
REQ-017 Counter arithmetic SHALL be p_width bits with no overflow path, since C never exceeds A <= 2^p_width-1.
REQ-018 Channels SHALL be fully independent; en and mode are sampled every edge.

Reset
REQ-019 With rst=1 at an edge, every channel SHALL reset to:
- S=A=p_reset_div, C=0, R=0, pend=0.
- clk_out=0, tick=0.
- Writes and en are ignored during rst.
REQ-020 After rst=0, behaviour SHALL follow REQ-006 from the first edge with en=1. With default parameters and mode=0, this reproduces a divide-by-4096 square wave.

Verification
REQ-021 Bench SHALL cover the following directed scenarios:
- Basic square wave: reset; write ch0 D=5; en[0]=1 -> period 6, clk_out 1,1,1,0,0,0 repeating; tick on each first high cycle.
- Pulse mode and odd duty: ch1 D=4, mode[1]=1, then mode[1]=0 -> pulse mode gives a 1-cycle pulse every 5 cycles; square mode gives high 3, low 2.
- Write at boundary: ch0 D=3 running; write D=7 on the edge where C==3 -> next period still 4 cycles with pend=1; following period 8 cycles, with pend cleared at its start.
- Disable mid-period: ch2 D=9 at C=4, en[2]=0 for 3 cycles, then en[2]=1 -> outputs 0 while disabled; restart at C=0 with tick=1 and a full 10-cycle period.
- D=0 and D=max edge cases: ch3 D=0 in square mode -> clk_out constant 1 with tick every cycle; p_width=4, D=15 -> high 8, low 8; wr_chan=p_nchan ignored.
- Reset mid-operation: all channels running, rst for 1 cycle -> all outputs 0 and S=A=p_reset_div; with en held at 1, restart on the next edge.
